// File: rtl/lpc_coeff_quantizer.sv
// LPC coefficient quantizer: buffers one float32 coefficient set, derives a shared shift from the
// largest exponent and emits PRECISION-bit coefficients with error-feedback rounding.
module lpc_coeff_quantizer #(
    parameter int PRECISION = 15,
    parameter int MAX_ORDER = 32,
    parameter int MAX_SHIFT = 15,
    parameter int FRAC      = 16
) (
    input  logic                         iClock,
    input  logic                         iReset_n,
    input  logic                         iEnable,
    input  logic                         iValid,
    input  logic                         iLast,
    input  logic [31:0]                  iFloatCoeff,
    output logic                         oReady,
    output logic                         oValid,
    output logic [PRECISION-1:0]         oQuantizedCoeff,
    output logic [$clog2(MAX_ORDER)-1:0] oIndex,
    output logic [4:0]                   oShift,
    output logic                         oLast
);
    localparam int IDXW = $clog2(MAX_ORDER);
    localparam int CNTW = $clog2(MAX_ORDER + 1);
    localparam int W    = PRECISION + FRAC + 2;
    // Headroom so a whole set of saturated coefficients cannot overflow the error accumulator.
    localparam int ACCW = W + IDXW + 2;

    localparam logic signed [W-1:0]    FIX_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]    FIX_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [ACCW-1:0] HALF    = ACCW'(1) << (FRAC - 1);
    localparam logic signed [ACCW-1:0] Q_MAX   = ACCW'((1 << (PRECISION - 1)) - 1);
    localparam logic signed [ACCW-1:0] Q_MIN   = -Q_MAX - ACCW'(1);

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_SHIFT,
        ST_EMIT
    } state_t;

    state_t                 r_state;
    state_t                 w_nextState;
    logic [31:0]            r_buf [MAX_ORDER];
    logic [CNTW-1:0]        r_count;
    logic [CNTW-1:0]        r_rdPtr;
    logic [7:0]             r_emax;
    logic signed [ACCW-1:0] r_err;
    logic [4:0]             r_shift;
    logic                   r_valid;
    logic                   r_last;
    logic [PRECISION-1:0]   r_coeff;
    logic [IDXW-1:0]        r_index;

    logic                   w_accept;
    logic                   w_closeSet;
    logic                   w_emitting;
    logic [7:0]             w_inExp;
    logic [31:0]            w_cur;
    logic [7:0]             w_exp;
    logic [23:0]            w_mant;
    int                     w_sh;
    int                     w_s;
    logic [4:0]             w_shiftNext;
    logic [W-1:0]           w_mag;
    logic signed [W-1:0]    w_fix;
    logic signed [ACCW-1:0] w_sum;
    logic signed [ACCW-1:0] w_qWide;
    logic signed [ACCW-1:0] w_qClamp;
    logic signed [ACCW-1:0] w_errNext;

    assign w_inExp    = iFloatCoeff[30:23];
    assign w_accept   = iEnable && iValid && (r_state == ST_COLLECT);
    assign w_closeSet = w_accept && (iLast || (r_count == CNTW'(MAX_ORDER - 1)));
    assign w_emitting = (r_rdPtr != r_count);

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_COLLECT: if (w_closeSet) w_nextState = ST_SHIFT;
            ST_SHIFT:   if (iEnable) w_nextState = ST_EMIT;
            ST_EMIT:    if (iEnable && !w_emitting) w_nextState = ST_COLLECT;
            default:    w_nextState = ST_COLLECT;
        endcase
    end

    always_comb begin
        w_s = PRECISION + 125 - int'(r_emax);
        if (r_emax == 8'd0 || w_s < 0) begin
            w_s = 0;
        end else if (w_s > MAX_SHIFT) begin
            w_s = MAX_SHIFT;
        end
        w_shiftNext = 5'(w_s);
    end

    // The implicit leading one sits at bit 23, so any left shift of W-24 or more overflows.
    always_comb begin
        w_cur  = r_buf[r_rdPtr[IDXW-1:0]];
        w_exp  = w_cur[30:23];
        w_mant = {1'b1, w_cur[22:0]};
        w_sh   = int'(w_exp) - 150 + int'(r_shift) + FRAC;
        w_mag  = '0;
        w_fix  = '0;
        if (w_exp == 8'd0) begin
            w_fix = '0;
        end else if (w_exp == 8'hFF || w_sh >= W - 24) begin
            w_fix = w_cur[31] ? FIX_MIN : FIX_MAX;
        end else begin
            if (w_sh >= 0) begin
                w_mag = W'(w_mant) << w_sh;
            end else if (w_sh > -24) begin
                w_mag = W'(w_mant) >> (-w_sh);
            end
            w_fix = w_cur[31] ? -$signed(w_mag) : $signed(w_mag);
        end

        w_sum   = ACCW'(w_fix) + r_err;
        w_qWide = (w_sum + HALF) >>> FRAC;
        if (w_qWide > Q_MAX) begin
            w_qClamp = Q_MAX;
        end else if (w_qWide < Q_MIN) begin
            w_qClamp = Q_MIN;
        end else begin
            w_qClamp = w_qWide;
        end
        w_errNext = w_sum - (w_qClamp <<< FRAC);
    end

    always_ff @(posedge iClock) begin
        if (w_accept) begin
            r_buf[r_count[IDXW-1:0]] <= iFloatCoeff;
        end
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            r_count <= '0;
            r_rdPtr <= '0;
            r_emax  <= '0;
            r_err   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_coeff <= '0;
            r_index <= '0;
        end else if (iEnable) begin
            case (r_state)
                ST_COLLECT: begin
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    if (iValid) begin
                        r_count <= r_count + 1'b1;
                        if (w_inExp != 8'd0 && w_inExp != 8'hFF && w_inExp > r_emax) begin
                            r_emax <= w_inExp;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_shift <= w_shiftNext;
                    r_err   <= '0;
                    r_rdPtr <= '0;
                end
                ST_EMIT: begin
                    if (w_emitting) begin
                        r_valid <= 1'b1;
                        r_coeff <= w_qClamp[PRECISION-1:0];
                        r_index <= r_rdPtr[IDXW-1:0];
                        r_last  <= (r_rdPtr == r_count - 1'b1);
                        r_err   <= w_errNext;
                        r_rdPtr <= r_rdPtr + 1'b1;
                    end else begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_count <= '0;
                        r_emax  <= '0;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign oReady          = (r_state == ST_COLLECT);
    assign oValid          = r_valid;
    assign oQuantizedCoeff = r_coeff;
    assign oIndex          = r_index;
    assign oShift          = r_shift;
    assign oLast           = r_last;

endmodule
